word_packer: RTL
================

# word_packer

Parametrised successor to the byte-to-word packer on the USB receive path. It pops IN_WIDTH-bit items from a first-word-fall-through FIFO and assembles LANES items into one output word. It sustains one item per clock and holds completed words under valid/ready backpressure. A flush request emits a partial word with its lane count. It sits between the USB RX FIFO and the command/operand decoder.

## Interface
- IN_WIDTH, 8, bits per FIFO item / lane
- LANES, 8, items per output word (≥2)
- LSB_FIRST, 1, 1: first item lands in lane 0 (bits IN_WIDTH-1:0); 0: first item lands in lane LANES-1
- clk_pll  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fifo_data  in  IN_WIDTH  FIFO head item, valid while fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_pop  out  1  combinational; head consumed at this edge
- flush  in  1  one-cycle request to emit the partial word
- out_data  out  IN_WIDTH*LANES  held output word
- out_count  out  $clog2(LANES+1)  valid lanes in out_data (LANES for a full word)
- out_last  out  1  word was produced by a flush
- out_valid  out  1  out_data/out_count/out_last valid
- out_ready  in  1  consumer accepts the word at this edge when out_valid=1

## Operation
- Internal state: assembly register asm (LANES lanes), count cnt (0..LANES-1), flush_pending, output register (data/count/last/valid).
- out_free = !out_valid || out_ready.
- fifo_pop = !reset && !fifo_empty && !flush_pending && (cnt != LANES-1 || out_free).
- On a pop, write fifo_data into lane cnt (LSB_FIRST=1) or lane LANES-1-cnt (LSB_FIRST=0).
  - cnt<LANES-1: cnt++.
  - cnt==LANES-1: transfer the completed word (including the popped item) to the output register; out_count=LANES, out_last=0, out_valid=1; cnt=0.
- flush=1 at edge N sets flush_pending. A pop in the same cycle still occurs and is included in the word.
- While flush_pending:
  - no pops;
  - at the first edge with out_free: if cnt>0, transfer asm with out_count=cnt, out_last=1, out_valid=1, and unfilled lanes zero; if cnt==0, emit nothing. In both cases cnt=0 and flush_pending=0.
- flush while flush_pending=1 is absorbed (no second word).
- Output handshake: out_valid=1 and out_ready=1 at an edge consumes the word. out_valid clears unless a new word loads at the same edge (back-to-back allowed). While out_valid=1 and out_ready=0, outputs hold stable.
- Asm lanes beyond cnt are cleared whenever cnt returns to 0.
- Reset: cnt=0, flush_pending=0, out_valid=0, out_data=0, out_count=0, out_last=0, asm cleared; fifo_pop=0 during reset. Reset mid-word discards the partial and held words; FIFO items not popped are untouched.

## Timing
- Throughput: one item per clock while the FIFO is non-empty and the output is free; LANES-cycle word period at full rate.
- Latency: out_valid rises one clock after the edge that pops the last item.
- Stall: with the output held and the next word complete except its last lane, fifo_pop=0 until out_ready. No item is lost or duplicated.
- Flush latency: partial word valid 2 clocks after the flush edge when the output is free.
- fifo_pop depends combinationally on fifo_empty, out_valid, out_ready and registered state only. There is no path from fifo_data.

## Test plan
- LANES=8, LSB_FIRST=1, out_ready=1, FIFO preloaded 0x01..0x10, then empty -> two words: 0x0807060504030201 and 0x100F0E0D0C0B0A09, out_count=8, out_last=0; fifo_pop high 16 consecutive cycles.
- Same stimulus with out_ready=0 until cycle 20 -> first word held stable; pops stop after item 15; second word appears the cycle after release; no loss.
- Push 0xAA,0xBB,0xCC then pulse flush -> out_data=0x0000000000CCBBAA, out_count=3, out_last=1; next word starts in lane 0.
- Flush with cnt=0, and flush on the same edge as the 8th pop -> exactly one full word, out_last=0, no empty word.
- LSB_FIRST=0, IN_WIDTH=4, LANES=4, items 1,2,3,4 -> out_data=0x1234.
- Reset asserted after 5 items with a held word pending -> out_valid=0 next clock; 8 new items form a clean word with no stale lanes.

Source files
------------

// File: rtl/word_packer.sv
// Packs LANES items of IN_WIDTH bits from a first-word-fall-through FIFO into one output word,
// with a flush request that emits a partial word tagged with its lane count.
module word_packer #(
   parameter int IN_WIDTH  = 8,
   parameter int LANES     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic                       clk_pll,
   input  logic                       reset,
   input  logic [IN_WIDTH-1:0]        fifo_data,
   input  logic                       fifo_empty,
   output logic                       fifo_pop,
   input  logic                       flush,
   output logic [IN_WIDTH*LANES-1:0]  out_data,
   output logic [$clog2(LANES+1)-1:0] out_count,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready
);
   localparam int OW = IN_WIDTH * LANES;
   localparam int CW = $clog2(LANES + 1);
   localparam int NW = $clog2(LANES);
   localparam logic [NW-1:0] LAST = NW'(LANES - 1);

   logic [OW-1:0] asm_q, asm_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic          flush_pq, flush_pd;
   logic [OW-1:0] out_data_q, out_data_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          out_last_q, out_last_d;
   logic          out_valid_q, out_valid_d;
   logic          out_free;
   int            lane;

   // The last lane may only be popped when the finished word has somewhere to go.
   assign out_free = !out_valid_q || out_ready;
   assign fifo_pop = !reset && !fifo_empty && !flush_pq && (cnt_q != LAST || out_free);

   always_comb begin
      asm_d       = asm_q;
      cnt_d       = cnt_q;
      flush_pd    = flush_pq;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      lane        = 0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (fifo_pop) begin
         lane = (LSB_FIRST != 0) ? int'(cnt_q) : (LANES - 1 - int'(cnt_q));
         asm_d[lane*IN_WIDTH +: IN_WIDTH] = fifo_data;
         if (cnt_q == LAST) begin
            out_data_d  = asm_d;
            out_count_d = CW'(LANES);
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            asm_d       = '0;
         end else begin
            cnt_d = cnt_q + NW'(1);
         end
      end

      // A pending flush blocks pops, so asm/cnt are stable until the output frees up.
      if (flush_pq) begin
         if (out_free) begin
            if (cnt_q != '0) begin
               out_data_d  = asm_q;
               out_count_d = CW'(cnt_q);
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
            end
            cnt_d    = '0;
            asm_d    = '0;
            flush_pd = 1'b0;
         end
      end else if (flush) begin
         flush_pd = 1'b1;
      end
   end

   always_ff @(posedge clk_pll) begin
      if (reset) begin
         asm_q       <= '0;
         cnt_q       <= '0;
         flush_pq    <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         flush_pq    <= flush_pd;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

endmodule
